// File: rtl/attn_tile_sequencer.sv
// Feed/control sequencer for the 4x4 attention systolic array: takes operand tiles from a stream,
// holds each one on the array for a fixed issue window and walks the row/column tile schedule of one head.
module attn_tile_sequencer #(
    parameter int WIDTH        = 8,
    parameter int ISSUE_CYCLES = 10,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CNT_W-1:0]      num_col_tiles,
    input  logic [CNT_W-1:0]      num_row_tiles,
    input  logic [16*WIDTH-1:0]   tile_a,
    input  logic [16*WIDTH-1:0]   tile_b,
    input  logic                  tile_valid,
    output logic                  tile_ready,
    output logic [16*WIDTH-1:0]   arr_a,
    output logic [16*WIDTH-1:0]   arr_b,
    output logic [7:0]            arr_enables,
    output logic                  arr_mul_integer,
    output logic                  arr_mul_fractions,
    output logic                  arr_mul_value,
    output logic                  arr_last_tile,
    output logic                  arr_end_of_row,
    output logic                  arr_end_of_head,
    output logic                  arr_reset_pe_n,
    output logic                  arr_reset_row_n,
    output logic                  arr_reset_head_n,
    input  logic                  arr_done,
    output logic                  busy,
    output logic                  done
);
    localparam int ICW = $clog2(ISSUE_CYCLES + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HCLR  = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] ISSUE = 3'd3;
    localparam logic [2:0] RCLR  = 3'd4;
    localparam logic [2:0] WAITD = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]           state_reg, state_next;
    logic [1:0]           mode_reg;
    logic [CNT_W-1:0]     ncol_reg, nrow_reg, col_cnt_reg, row_cnt_reg;
    logic [ICW-1:0]       issue_cnt_reg;
    logic [16*WIDTH-1:0]  arr_a_reg, arr_b_reg;
    logic                 reset_pe_n_reg, reset_row_n_reg, reset_head_n_reg;

    logic in_issue, last_col, last_row, issue_end, accept;

    assign in_issue  = (state_reg == ISSUE);
    assign last_col  = (col_cnt_reg == ncol_reg - CNT_W'(1));
    assign last_row  = (row_cnt_reg == nrow_reg - CNT_W'(1));
    assign issue_end = in_issue && (issue_cnt_reg == ICW'(ISSUE_CYCLES - 1));
    assign accept    = (state_reg == LOAD) && tile_valid;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = HCLR;
            HCLR:    state_next = LOAD;
            LOAD:    if (tile_valid) state_next = ISSUE;
            ISSUE: begin
                if (issue_end) begin
                    if (!last_col)      state_next = LOAD;
                    else if (!last_row) state_next = RCLR;
                    else                state_next = WAITD;
                end
            end
            RCLR:    state_next = LOAD;
            WAITD:   if (arr_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            mode_reg         <= 2'd0;
            ncol_reg         <= '0;
            nrow_reg         <= '0;
            col_cnt_reg      <= '0;
            row_cnt_reg      <= '0;
            issue_cnt_reg    <= '0;
            arr_a_reg        <= '0;
            arr_b_reg        <= '0;
            reset_pe_n_reg   <= 1'b0;
            reset_row_n_reg  <= 1'b0;
            reset_head_n_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Clears are registered off the next state so they are low exactly in HCLR/RCLR.
            reset_head_n_reg <= (state_next != HCLR);
            reset_row_n_reg  <= (state_next != HCLR);
            reset_pe_n_reg   <= (state_next != RCLR);

            if (state_reg == IDLE && start) begin
                mode_reg    <= mode;
                ncol_reg    <= (num_col_tiles == '0) ? CNT_W'(1) : num_col_tiles;
                nrow_reg    <= (num_row_tiles == '0) ? CNT_W'(1) : num_row_tiles;
                col_cnt_reg <= '0;
                row_cnt_reg <= '0;
            end

            if (accept) begin
                arr_a_reg     <= tile_a;
                arr_b_reg     <= tile_b;
                issue_cnt_reg <= '0;
            end

            if (in_issue) begin
                issue_cnt_reg <= issue_cnt_reg + ICW'(1);
                // Counters advance only at the window end so the row/head flags stay stable while issuing.
                if (issue_end) begin
                    if (!last_col) begin
                        col_cnt_reg <= col_cnt_reg + CNT_W'(1);
                    end else if (!last_row) begin
                        col_cnt_reg <= '0;
                        row_cnt_reg <= row_cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign tile_ready        = (state_reg == LOAD);
    assign busy              = (state_reg != IDLE);
    assign done              = (state_reg == DONE);
    assign arr_a             = arr_a_reg;
    assign arr_b             = arr_b_reg;
    assign arr_enables       = in_issue ? 8'hFF : 8'h00;
    // Reserved mode 3 falls back to integer multiply.
    assign arr_mul_integer   = in_issue && (mode_reg == 2'd0 || mode_reg == 2'd3);
    assign arr_mul_fractions = in_issue && (mode_reg == 2'd1);
    assign arr_mul_value     = in_issue && (mode_reg == 2'd2);
    assign arr_last_tile     = in_issue && last_col;
    assign arr_end_of_row    = in_issue && last_col;
    assign arr_end_of_head   = in_issue && last_col && last_row;
    assign arr_reset_pe_n    = reset_pe_n_reg;
    assign arr_reset_row_n   = reset_row_n_reg;
    assign arr_reset_head_n  = reset_head_n_reg;
endmodule

// File: tb/tb_attn_tile_sequencer.sv
// Directed bench for attn_tile_sequencer: a table of head configurations run back to back,
// plus a hand-written reset-during-issue sequence.
module tb_attn_tile_sequencer;
    localparam int WIDTH = 8;
    localparam int ISSUE_CYCLES = 10;
    localparam int CNT_W = 8;
    localparam int TW = 16 * WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] num_col_tiles, num_row_tiles;
    logic [TW-1:0]    tile_a, tile_b;
    logic             tile_valid;
    logic             tile_ready;
    logic [TW-1:0]    arr_a, arr_b;
    logic [7:0]       arr_enables;
    logic             arr_mul_integer, arr_mul_fractions, arr_mul_value;
    logic             arr_last_tile, arr_end_of_row, arr_end_of_head;
    logic             arr_reset_pe_n, arr_reset_row_n, arr_reset_head_n;
    logic             arr_done;
    logic             busy, done;

    attn_tile_sequencer #(.WIDTH(WIDTH), .ISSUE_CYCLES(ISSUE_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .num_col_tiles(num_col_tiles), .num_row_tiles(num_row_tiles),
        .tile_a(tile_a), .tile_b(tile_b), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .arr_a(arr_a), .arr_b(arr_b), .arr_enables(arr_enables),
        .arr_mul_integer(arr_mul_integer), .arr_mul_fractions(arr_mul_fractions),
        .arr_mul_value(arr_mul_value), .arr_last_tile(arr_last_tile),
        .arr_end_of_row(arr_end_of_row), .arr_end_of_head(arr_end_of_head),
        .arr_reset_pe_n(arr_reset_pe_n), .arr_reset_row_n(arr_reset_row_n),
        .arr_reset_head_n(arr_reset_head_n), .arr_done(arr_done),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       mode;
        logic [CNT_W-1:0] ncol;
        logic [CNT_W-1:0] nrow;
        int               bp;      // cycles of tile_valid low before the first tile
        logic             early;   // arr_done held high for the whole head
        logic             poke;    // pulse start in the middle of every issue window
        logic [2:0]       flags;   // expected {integer, fractions, value}
    } vec_t;

    int tests = 0;
    int fails = 0;
    int tix = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] pat(input logic [7:0] seed);
        logic [TW-1:0] p;
        for (int i = 0; i < 16; i++) p[i*WIDTH +: WIDTH] = seed + 8'(i);
        return p;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_en"}, TW'(arr_enables), TW'(0));
        chk({tag, "_flags"}, TW'({arr_mul_integer, arr_mul_fractions, arr_mul_value,
                                  arr_last_tile, arr_end_of_row, arr_end_of_head}), TW'(0));
        chk({tag, "_busy"}, TW'(busy), TW'(0));
        chk({tag, "_ready"}, TW'(tile_ready), TW'(0));
        chk({tag, "_done"}, TW'(done), TW'(0));
    endtask

    task automatic run_head(input vec_t v, input int id);
        int nc, nr;
        logic [TW-1:0] ea, eb;
        logic lst, hd;
        nc = (v.ncol == 0) ? 1 : int'(v.ncol);
        nr = (v.nrow == 0) ? 1 : int'(v.nrow);
        arr_done = v.early;
        start = 1'b1; mode = v.mode; num_col_tiles = v.ncol; num_row_tiles = v.nrow;
        tick();
        start = 1'b0;
        chk("hclr_head_n", TW'(arr_reset_head_n), TW'(0));
        chk("hclr_row_n", TW'(arr_reset_row_n), TW'(0));
        chk("hclr_busy", TW'(busy), TW'(1));
        chk("hclr_ready", TW'(tile_ready), TW'(0));
        tick();
        chk("load_head_n", TW'(arr_reset_head_n), TW'(1));
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                chk("load_ready", TW'(tile_ready), TW'(1));
                chk("load_en", TW'(arr_enables), TW'(0));
                if (r == 0 && c == 0) begin
                    tile_valid = 1'b0;
                    for (int k = 0; k < v.bp; k++) begin
                        tick();
                        chk("bp_en", TW'(arr_enables), TW'(0));
                        chk("bp_ready", TW'(tile_ready), TW'(1));
                    end
                end
                ea = pat(8'(1 + tix * 17));
                eb = pat(8'(8'h80 + tix * 17));
                tix++;
                tile_a = ea; tile_b = eb; tile_valid = 1'b1;
                tick();
                lst = (c == nc - 1);
                hd  = lst && (r == nr - 1);
                for (int i = 0; i < ISSUE_CYCLES; i++) begin
                    chk("iss_en", TW'(arr_enables), TW'(8'hFF));
                    chk("iss_a", arr_a, ea);
                    chk("iss_b", arr_b, eb);
                    chk("iss_mode", TW'({arr_mul_integer, arr_mul_fractions, arr_mul_value}), TW'(v.flags));
                    chk("iss_last", TW'(arr_last_tile), TW'(lst));
                    chk("iss_row", TW'(arr_end_of_row), TW'(lst));
                    chk("iss_head", TW'(arr_end_of_head), TW'(hd));
                    chk("iss_ready", TW'(tile_ready), TW'(0));
                    tile_a = ~ea;
                    tile_b = ~eb;
                    start = v.poke && (i == 3);
                    tick();
                end
                start = 1'b0;
                chk("post_iss_en", TW'(arr_enables), TW'(0));
                if (lst && r < nr - 1) begin
                    chk("rclr_pe_n", TW'(arr_reset_pe_n), TW'(0));
                    chk("rclr_row_n", TW'(arr_reset_row_n), TW'(1));
                    chk("rclr_ready", TW'(tile_ready), TW'(0));
                    tick();
                    chk("rclr_pe_n_after", TW'(arr_reset_pe_n), TW'(1));
                end else begin
                    chk("no_pe_clr", TW'(arr_reset_pe_n), TW'(1));
                end
            end
        end
        tile_valid = 1'b0;
        chk("waitd_busy", TW'(busy), TW'(1));
        chk("waitd_done", TW'(done), TW'(0));
        chk("waitd_ready", TW'(tile_ready), TW'(0));
        if (!v.early) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("waitd_hold", TW'(done), TW'(0));
                chk("waitd_hold_busy", TW'(busy), TW'(1));
            end
            arr_done = 1'b1;
        end
        tick();
        chk("done_pulse", TW'(done), TW'(1));
        chk("done_busy", TW'(busy), TW'(1));
        arr_done = 1'b0;
        tick();
        chk_idle_outputs("after_done");
        $display("[TB] head %0d mode=%0d ncol=%0d nrow=%0d complete", id, v.mode, v.ncol, v.nrow);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{mode: 2'd0, ncol: 8'd1, nrow: 8'd1, bp: 0, early: 1'b0, poke: 1'b0, flags: 3'b100};
        vecs[1] = '{mode: 2'd1, ncol: 8'd3, nrow: 8'd2, bp: 0, early: 1'b0, poke: 1'b0, flags: 3'b010};
        vecs[2] = '{mode: 2'd2, ncol: 8'd2, nrow: 8'd1, bp: 5, early: 1'b0, poke: 1'b1, flags: 3'b001};
        vecs[3] = '{mode: 2'd3, ncol: 8'd0, nrow: 8'd0, bp: 0, early: 1'b1, poke: 1'b0, flags: 3'b100};
        vecs[4] = '{mode: 2'd0, ncol: 8'd1, nrow: 8'd3, bp: 2, early: 1'b1, poke: 1'b1, flags: 3'b100};

        reset = 1'b1; start = 1'b0; mode = 2'd0; num_col_tiles = '0; num_row_tiles = '0;
        tile_a = '0; tile_b = '0; tile_valid = 1'b0; arr_done = 1'b0;
        tick(); tick();
        chk_idle_outputs("rst");
        chk("rst_a", arr_a, '0);
        chk("rst_head_n", TW'(arr_reset_head_n), TW'(0));
        chk("rst_pe_n", TW'(arr_reset_pe_n), TW'(0));
        reset = 1'b0;
        tick();
        chk("rel_clears", TW'({arr_reset_pe_n, arr_reset_row_n, arr_reset_head_n}), TW'(3'b111));
        chk("rel_busy", TW'(busy), TW'(0));

        // Reset asserted in the middle of an issue window.
        start = 1'b1; mode = 2'd1; num_col_tiles = 8'd2; num_row_tiles = 8'd1;
        tick();
        start = 1'b0;
        tick();
        tile_a = pat(8'h40); tile_b = pat(8'h60); tile_valid = 1'b1;
        tick();
        tick(); tick();
        chk("pre_rst_en", TW'(arr_enables), TW'(8'hFF));
        chk("pre_rst_a", arr_a, pat(8'h40));
        reset = 1'b1;
        #1;
        chk_idle_outputs("mid_rst");
        chk("mid_rst_a", arr_a, '0);
        chk("mid_rst_b", arr_b, '0);
        chk("mid_rst_clears", TW'({arr_reset_pe_n, arr_reset_row_n, arr_reset_head_n}), TW'(0));
        tick(); tick();
        chk_idle_outputs("mid_rst_hold");
        chk("mid_rst_hold_clr", TW'(arr_reset_head_n), TW'(0));
        reset = 1'b0; tile_valid = 1'b0;
        tick();
        chk("mid_rel_clears", TW'({arr_reset_pe_n, arr_reset_row_n, arr_reset_head_n}), TW'(3'b111));
        chk_idle_outputs("mid_rel");
        $display("[TB] reset during issue sequence complete");

        // Heads run back to back: each start lands on the cycle right after the previous done.
        for (int h = 0; h < 5; h++) run_head(vecs[h], h);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
